// File: rtl/convolution_mac_if.sv
// convolution_mac_if: memory-controller read stream carrying interleaved coefficient and delayed-sample words
// Signals: valid (word present), is_coef (1 = coefficient, 0 = sample), data (signed Q1.15)
// Modports: master drives the stream, slave consumes it
interface convolution_mac_if;
    logic        valid;
    logic        is_coef;
    logic [15:0] data;
    modport master (output valid, is_coef, data);
    modport slave  (input  valid, is_coef, data);
endinterface

// File: rtl/convolution_mac.sv
// convolution_mac: per-frame multiply-accumulate of coefficient/sample pairs with one saturated Q1.15 output per frame
// Ports: clk, rst_n (synchronous, active low); sample_strobe + impulses start a frame of n taps;
//        gain (unsigned Q4.12, used only with GAIN_STAGE_EN); mem (convolution_mac_if.slave) read stream;
//        sample_out/sample_valid result, busy (not IDLE), seq_err (word dropped), frame_overrun (sticky abort flag)
// Optional macro: GAIN_STAGE_EN adds a GAIN state applying the output gain, one cycle more latency
module convolution_mac #(
    parameter int ACC_W     = 48,
    parameter int FRAC_BITS = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_strobe,
    input  logic [15:0]             impulses,
    input  logic [15:0]             gain,
    convolution_mac_if.slave        mem,
    output logic [15:0]             sample_out,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    seq_err,
    output logic                    frame_overrun
);
    typedef enum logic [2:0] {IDLE, WAIT_COEF, WAIT_SAMP, MAC, GAIN, DONE} state_t;
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-32768);
    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_sh;
    logic [15:0]             taps_q, taps_d, n_taps_q, n_taps_d, taps_inc;
    logic signed [15:0]      coef_q, coef_d, samp_q, samp_d, sat_s, fin;
    logic signed [31:0]      prod;
    logic [15:0]             out_q, out_d;
    logic                    valid_q, valid_d, err_q, err_d, ovr_q, ovr_d;
    assign prod     = 32'(coef_q) * 32'(samp_q);
    assign acc_sh   = acc_q >>> FRAC_BITS;
    assign sat_s    = acc_sh > MAX_V ? 16'sh7FFF : acc_sh < MIN_V ? 16'sh8000 : acc_sh[15:0];
    assign taps_inc = taps_q + 16'd1;
`ifdef GAIN_STAGE_EN
    localparam state_t MAC_NEXT = GAIN;
    logic signed [32:0] gain_p, gain_sh;
    logic signed [15:0] gain_y, res_q, res_d;
    assign gain_p  = 33'(sat_s) * 33'($signed({1'b0, gain}));
    assign gain_sh = gain_p >>> 12;
    assign gain_y  = gain_sh > 33'sd32767 ? 16'sh7FFF : gain_sh < -33'sd32768 ? 16'sh8000 : gain_sh[15:0];
    assign fin     = res_q;
`else
    localparam state_t MAC_NEXT = DONE;
    logic unused_gain;
    assign unused_gain = ^gain;
    assign fin         = sat_s;
`endif
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        taps_d   = taps_q;
        n_taps_d = n_taps_q;
        coef_d   = coef_q;
        samp_d   = samp_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        ovr_d    = ovr_q;
`ifdef GAIN_STAGE_EN
        res_d    = res_q;
`endif
        // A strobe restarts the frame from any state and swallows any word in the same cycle
        if (sample_strobe) begin
            acc_d    = '0;
            taps_d   = '0;
            n_taps_d = impulses;
            state_d  = impulses == 16'd0 ? DONE : WAIT_COEF;
            ovr_d    = ovr_q | (state_q != IDLE);
`ifdef GAIN_STAGE_EN
            res_d    = '0;
`endif
        end else begin
            case (state_q)
                WAIT_COEF: if (mem.valid) begin
                    if (mem.is_coef) begin
                        coef_d  = mem.data;
                        state_d = WAIT_SAMP;
                    end else err_d = 1'b1;
                end
                WAIT_SAMP: if (mem.valid) begin
                    if (!mem.is_coef) begin
                        samp_d  = mem.data;
                        state_d = MAC;
                    end else err_d = 1'b1;
                end
                MAC: begin
                    acc_d   = acc_q + ACC_W'(prod);
                    taps_d  = taps_inc;
                    state_d = taps_inc == n_taps_q ? MAC_NEXT : WAIT_COEF;
                end
`ifdef GAIN_STAGE_EN
                GAIN: begin
                    res_d   = gain_y;
                    state_d = DONE;
                end
`endif
                DONE: begin
                    out_d   = fin;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            taps_q   <= '0;
            n_taps_q <= '0;
            coef_q   <= '0;
            samp_q   <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef GAIN_STAGE_EN
            res_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            taps_q   <= taps_d;
            n_taps_q <= n_taps_d;
            coef_q   <= coef_d;
            samp_q   <= samp_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
`ifdef GAIN_STAGE_EN
            res_q    <= res_d;
`endif
        end
    end
    assign sample_out    = out_q;
    assign sample_valid  = valid_q;
    assign busy          = state_q != IDLE;
    assign seq_err       = err_q;
    assign frame_overrun = ovr_q;
endmodule

// File: tb/tb_convolution_mac.sv
// tb_convolution_mac: table-driven frames plus hand sequences for overrun, strobe priority and mid-frame reset
module tb_convolution_mac;
    logic        clk = 1'b0, rst_n = 1'b0, sample_strobe = 1'b0;
    logic [15:0] impulses = 16'd0, gain = 16'h1000;
    logic [15:0] sample_out;
    logic        sample_valid, busy, seq_err, frame_overrun;
    int          checks = 0, failures = 0, err_cnt = 0, vld_cnt = 0;
`ifdef GAIN_STAGE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    typedef struct {
        logic [15:0] n;
        logic [15:0] c;
        logic [15:0] s;
        int          bad;
        logic [15:0] exp_o;
        int          exp_e;
    } vec_t;
    vec_t vecs[8];
    convolution_mac_if mem_if();
    convolution_mac dut (
        .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe), .impulses(impulses), .gain(gain),
        .mem(mem_if), .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
        .seq_err(seq_err), .frame_overrun(frame_overrun)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (seq_err) err_cnt++;
        if (sample_valid) vld_cnt++;
    end
    task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic send_word(input logic is_c, input logic [15:0] d);
        mem_if.valid = 1'b1;
        mem_if.is_coef = is_c;
        mem_if.data = d;
        @(posedge clk); #1;
        mem_if.valid = 1'b0;
    endtask
    task automatic run_frame(input string nm, input logic [15:0] n, input logic [15:0] c, input logic [15:0] s,
                             input int bad, input logic [15:0] g, input logic [15:0] exp_o, input int exp_e);
        int lat, e0, v0;
        e0 = err_cnt;
        v0 = vld_cnt;
        gain = g;
        impulses = n;
        sample_strobe = 1'b1;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        for (int i = 0; i < bad; i++) send_word(1'b0, 16'h1234);
        for (int t = 0; t < int'(n); t++) begin
            send_word(1'b1, c);
            send_word(1'b0, s);
            if (t != int'(n) - 1) begin
                @(posedge clk); #1;
            end
        end
        lat = 0;
        while (!sample_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_lat"}, lat, n == 16'd0 ? 1 : LAT);
        check({nm, "_out"}, sample_out, exp_o);
        check({nm, "_busy"}, busy, 0);
        @(posedge clk); #1;
        check({nm, "_pulse"}, sample_valid, 0);
        check({nm, "_vcnt"}, vld_cnt - v0, 1);
        check({nm, "_errs"}, err_cnt - e0, exp_e);
    endtask
    initial begin
        int e0, v0;
        vecs[0] = '{16'd1, 16'h4000, 16'h2000, 0, 16'h1000, 0};
        vecs[1] = '{16'd4, 16'h7FFF, 16'h7FFF, 0, 16'h7FFF, 0};
        vecs[2] = '{16'd4, 16'h8000, 16'h7FFF, 0, 16'h8000, 0};
        vecs[3] = '{16'd0, 16'h0000, 16'h0000, 0, 16'h0000, 0};
        vecs[4] = '{16'd2, 16'h4000, 16'h4000, 2, 16'h4000, 2};
        vecs[5] = '{16'd3, 16'h8000, 16'h8000, 0, 16'h7FFF, 0};
        vecs[6] = '{16'd2, 16'hC000, 16'h4000, 0, 16'hC000, 0};
        vecs[7] = '{16'd1, 16'hFFFF, 16'h0001, 0, 16'hFFFF, 0};
        mem_if.valid = 1'b0;
        mem_if.is_coef = 1'b0;
        mem_if.data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", sample_out, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", seq_err, 0);
        check("rst_ovr", frame_overrun, 0);
        rst_n = 1'b1;
        e0 = err_cnt;
        send_word(1'b0, 16'h5555);
        send_word(1'b1, 16'h5555);
        @(posedge clk); #1;
        check("idle_errs", err_cnt - e0, 0);
        check("idle_busy", busy, 0);
        for (int i = 0; i < 8; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].n, vecs[i].c, vecs[i].s, vecs[i].bad, 16'h1000,
                      vecs[i].exp_o, vecs[i].exp_e);
`ifdef GAIN_STAGE_EN
        run_frame("gain_x2", 16'd1, 16'h4000, 16'h2000, 0, 16'h2000, 16'h2000, 0);
        run_frame("gain_sat", 16'd2, 16'h4000, 16'h4000, 0, 16'h8000, 16'h7FFF, 0);
`else
        run_frame("gain_unused", 16'd1, 16'h4000, 16'h2000, 0, 16'h2000, 16'h1000, 0);
`endif
        gain = 16'h1000;
        v0 = vld_cnt;
        impulses = 16'd8;
        sample_strobe = 1'b1;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        for (int t = 0; t < 3; t++) begin
            send_word(1'b1, 16'h4000);
            send_word(1'b0, 16'h4000);
            @(posedge clk); #1;
        end
        check("ovr_before", frame_overrun, 0);
        check("ovr_busy", busy, 1);
        mem_if.valid = 1'b1;
        mem_if.is_coef = 1'b0;
        mem_if.data = 16'h7777;
        run_frame("ovr_new", 16'd1, 16'h4000, 16'h2000, 0, 16'h1000, 16'h1000, 0);
        check("ovr_set", frame_overrun, 1);
        check("ovr_vcnt", vld_cnt - v0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("ovr_sticky", frame_overrun, 1);
        impulses = 16'd2;
        sample_strobe = 1'b1;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        send_word(1'b1, 16'h4000);
        send_word(1'b0, 16'h4000);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        v0 = vld_cnt;
        check("mrst_busy", busy, 0);
        check("mrst_ovr", frame_overrun, 0);
        check("mrst_out", sample_out, 0);
        repeat (5) @(posedge clk);
        #1;
        check("mrst_vcnt", vld_cnt - v0, 0);
        check("mrst_idle", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
